// File: rtl/klp32_pkg.sv
// Shared types and constants for the KLP32 fetch path.
package klp32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/klp32_fetch_queue.sv
// In-order sync FIFO with flush; head is read combinationally (0-cycle), push visible next cycle.
// Flush wins over push/pop; push is only accepted when a slot is free or a pop frees one.
module klp32_fetch_queue
  import klp32_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           push_dat_i,
  input  logic                       pop_i,
  output T                           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/klp32_fetch_unit.sv
// KLP32 fetch stage: credit-limited imem requests, PC-tagged prefetch queue, redirect flush.
// Request->inst_valid = memory latency + 1; requests stop when queue + in-flight reach depth.
module klp32_fetch_unit
  import klp32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam int CW = $clog2(QUEUE_DEPTH+1);

  logic [1:0]      rst_sync_q;
  logic            rst_sync_n;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   pq_count, in_flight, in_flight_nxt;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_fire, drop_rsp, pq_push, inst_fire;
  fetch_entry_t    pq_head, pq_push_dat;
  logic [XLEN-1:0] tag_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  assign credit_used    = {1'b0, pq_count} + {1'b0, in_flight};
  assign imem_req_valid = rst_sync_n && !redirect_valid && (credit_used < (CW+1)'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_fire  = imem_rsp_valid && (in_flight != '0);
  assign drop_rsp  = rsp_fire && (drop_cnt_q != '0);
  assign pq_push   = rsp_fire && !drop_rsp && !redirect_valid;
  assign inst_fire = inst_valid && inst_ready;
  assign in_flight_nxt = in_flight + CW'(req_fire) - CW'(rsp_fire);

  assign pq_push_dat = '{pc: tag_pc, inst: imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (drop_rsp) drop_cnt_d = drop_cnt_q - CW'(1);
    // Everything still outstanding after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt_d = in_flight_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  klp32_fetch_queue #(.T(fetch_entry_t), .DEPTH(QUEUE_DEPTH)) u_prefetch_q (
    .clk        (clk),
    .rst_n      (rst_sync_n),
    .flush_i    (redirect_valid),
    .push_i     (pq_push),
    .push_dat_i (pq_push_dat),
    .pop_i      (inst_fire),
    .head_o     (pq_head),
    .count_o    (pq_count)
  );

  // Tags are never flushed: dropped responses still retire their tag, so count == in-flight.
  klp32_fetch_queue #(.T(logic [XLEN-1:0]), .DEPTH(QUEUE_DEPTH)) u_tag_q (
    .clk        (clk),
    .rst_n      (rst_sync_n),
    .flush_i    (1'b0),
    .push_i     (req_fire),
    .push_dat_i (fetch_pc_q),
    .pop_i      (rsp_fire),
    .head_o     (tag_pc),
    .count_o    (in_flight)
  );

  assign inst_valid = (pq_count != '0);
  assign inst       = inst_valid ? pq_head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? pq_head.pc   : RESET_PC;

  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_sync_n)
                                  imem_rsp_valid |-> (in_flight != '0));
endmodule

// File: tb/tb_klp32_fetch_unit.sv
// Randomized bench for klp32_fetch_unit: in-order memory model plus a PC-stream reference scoreboard.
module tb_klp32_fetch_unit;
  import klp32_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, inst, inst_pc;

  klp32_fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, lat = 1, outstanding = 0, n_acc = 0, n_deliv = 0;
  bit rdy_rand = 0;
  logic [31:0] start_q[$];

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: fixed latency per phase, strictly in-order returns, optional random ready.
  initial begin : mem_model
    pend_t p;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend.delete();
        outstanding = 0;
      end else begin
        if (imem_rsp_valid) outstanding--;
        if (imem_req_valid && imem_req_ready) begin
          p.addr = imem_req_addr;
          p.due  = cyc + lat;
          pend.push_back(p);
          outstanding++;
          n_acc++;
          chk("credit_bound", 32'(outstanding <= DEPTH), 32'd1);
          chk("addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
        end
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = img(pend[0].addr);
        void'(pend.pop_front());
      end
      imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference: consumed PCs form +4 runs starting at RESET_PC or at each redirect target.
  initial begin : monitor
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_stall;
    exp_pc     = RPC;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_pc     = RPC;
        prev_stall = 1'b0;
      end else begin
        if (inst_valid && inst_ready) begin
          chk("inst_pc", inst_pc, exp_pc);
          chk("inst_word", inst, img(exp_pc));
          exp_pc += 32'd4;
          n_deliv++;
        end
        if (redirect_valid) begin
          if (start_q.size() > 0) exp_pc = start_q.pop_front();
          else begin
            n_tests++;
            n_fail++;
            $display("FAIL redirect_model: got redirect expected none");
          end
        end
        if (prev_stall && imem_req_valid) chk("addr_stable", imem_req_addr, prev_addr);
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
      end
    end
  end

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    start_q.push_back({tgt[31:2], 2'b00});
    step();
    redirect_valid = 1'b0;
    chk("flush_empty", 32'(inst_valid), 32'd0);
  endtask

  task automatic wait_deliv(input int n, input int budget, input string name);
    int t0, k;
    t0 = n_deliv;
    k  = 0;
    while (n_deliv < t0 + n && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(n_deliv - t0 >= n), 32'd1);
  endtask

  task automatic run_rand(input int n, input bit redir_en, input string name);
    int t0, k;
    t0 = n_deliv;
    k  = 0;
    while (n_deliv < t0 + n && k < 8000) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if (redir_en && $urandom_range(0, 39) == 0) redirect_to($urandom);
      else step();
      k++;
    end
    chk(name, 32'(n_deliv - t0 >= n), 32'd1);
  endtask

  initial begin : stim
    int k, t0;
    reset          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, NOP_INST);
    chk("rst_inst_pc", inst_pc, RPC);
    chk("rst_req_addr", imem_req_addr, RPC);

    // Core stalled from reset: only DEPTH requests may go out.
    reset = 1'b1;
    t0 = n_acc;
    repeat (12) step();
    chk("stall_req_count", n_acc - t0, DEPTH);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);

    inst_ready = 1'b1;
    wait_deliv(30, 200, "stream_lat1");

    // Redirect while both credits are in flight at latency 3.
    lat = 3;
    k = 0;
    while (outstanding != DEPTH && k < 50) begin step(); k++; end
    chk("two_in_flight", outstanding, DEPTH);
    redirect_to(32'h40);
    wait_deliv(6, 200, "after_redirect_40");

    // Redirect coinciding with a dequeue, unaligned target.
    lat = 1;
    k = 0;
    while (!inst_valid && k < 50) begin step(); k++; end
    chk("deq_before_redirect", 32'(inst_valid), 32'd1);
    redirect_to(32'h103);
    wait_deliv(6, 200, "after_redirect_103");

    rdy_rand = 1'b1;
    lat = 2;
    run_rand(200, 1'b0, "rand_ready_200");
    lat = 1;
    run_rand(80, 1'b1, "rand_redirect_lat1");
    lat = 4;
    run_rand(80, 1'b1, "rand_redirect_lat4");

    // Reset with the prefetch queue full.
    rdy_rand   = 1'b0;
    lat        = 2;
    inst_ready = 1'b0;
    repeat (10) step();
    chk("full_before_reset", 32'(inst_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_rst_req_addr", imem_req_addr, RPC);
    step();
    step();
    reset      = 1'b1;
    inst_ready = 1'b1;
    wait_deliv(10, 200, "after_mid_reset");

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
